// File: rtl/config_frame_sequencer_if.sv
// Config word stream from the bitstream bridge; valid/ready handshake, transfer on s_valid & s_ready.
// Combinational pass-through bundle: no latency, the master holds data while ready is low.
interface config_frame_sequencer_if;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/config_frame_sequencer.sv
// Parses SYNC + per-frame commands, gathers NUM_ROWS words, then pulses one FrameStrobe bit (edge after last word).
// Latency: last word at edge N -> strobe cycle N+1 -> s_ready back in N+3; s_ready low only in STROBE/HOLD.
module config_frame_sequencer #(
  parameter int          NUM_ROWS       = 8,
  parameter int          NUM_COLUMNS    = 8,
  parameter int          FRAMES_PER_COL = 20,
  parameter logic [31:0] SYNC_WORD      = 32'hFAB0_FAB1
) (
  input  logic                                  CLK,
  input  logic                                  reset,
  config_frame_sequencer_if.slave               s,
  output logic [32*NUM_ROWS-1:0]                FrameData,
  output logic [NUM_COLUMNS*FRAMES_PER_COL-1:0] FrameStrobe,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  err
);

  localparam int STRB_W = NUM_COLUMNS * FRAMES_PER_COL;
  localparam int IDX_W  = (STRB_W > 1) ? $clog2(STRB_W) : 1;
  localparam int CNT_W  = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_END   = 8'h02;
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(NUM_ROWS - 1);

  typedef enum logic [2:0] {IDLE, CMD, DATA, STROBE, HOLD} state_t;

  state_t           state;
  logic [CNT_W-1:0] word_cnt;
  logic [IDX_W-1:0] tgt_idx;
  logic             discard;

  logic        accept;
  logic [7:0]  opcode;
  logic [7:0]  col;
  logic [15:0] frame;
  logic        in_range;

  assign accept   = s.s_valid & s.s_ready;
  assign opcode   = s.s_data[31:24];
  assign col      = s.s_data[23:16];
  assign frame    = s.s_data[15:0];
  assign in_range = (int'(col) < NUM_COLUMNS) && (int'(frame) < FRAMES_PER_COL);

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      FrameData   <= '0;
      FrameStrobe <= '0;
      s.s_ready   <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      word_cnt    <= '0;
      tgt_idx     <= '0;
      discard     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && s.s_data == SYNC_WORD) begin
            state <= CMD;
            busy  <= 1'b1;
            err   <= 1'b0;
          end
        end
        CMD: begin
          if (accept) begin
            case (opcode)
              OP_WRITE: begin
                // Out-of-range targets still consume their data words so the stream stays aligned.
                state   <= DATA;
                discard <= !in_range;
                tgt_idx <= IDX_W'(int'(col) * FRAMES_PER_COL + int'(frame));
                if (!in_range) err <= 1'b1;
              end
              OP_END: begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
              default: begin
                state <= IDLE;
                busy  <= 1'b0;
                err   <= 1'b1;
              end
            endcase
          end
        end
        DATA: begin
          if (accept) begin
            FrameData[32*word_cnt +: 32] <= s.s_data;
            if (word_cnt == LAST_ROW) begin
              word_cnt <= '0;
              if (discard) begin
                state <= CMD;
              end else begin
                state                <= STROBE;
                s.s_ready            <= 1'b0;
                FrameStrobe[tgt_idx] <= 1'b1;
              end
            end else begin
              word_cnt <= word_cnt + CNT_W'(1);
            end
          end
        end
        STROBE: begin
          state       <= HOLD;
          FrameStrobe <= '0;
        end
        HOLD: begin
          // FrameData stays put one more cycle after the strobe falls for latch hold time.
          state     <= CMD;
          s.s_ready <= 1'b1;
        end
        default: begin
          state       <= IDLE;
          FrameStrobe <= '0;
          s.s_ready   <= 1'b1;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_config_frame_sequencer.sv
// Bench for config_frame_sequencer: frame-level model of expected strobes/data vs observed monitor queues.
module tb_config_frame_sequencer;
  localparam int NR  = 8;
  localparam int NC  = 8;
  localparam int FPC = 20;
  localparam int SW  = NC * FPC;
  localparam int FDW = 32 * NR;
  localparam logic [31:0] SYNC    = 32'hFAB0_FAB1;
  localparam logic [31:0] END_CMD = 32'h0200_0000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  config_frame_sequencer_if sif ();
  logic [FDW-1:0] frame_data;
  logic [SW-1:0]  frame_strobe;
  logic           busy, done, err;

  config_frame_sequencer #(
    .NUM_ROWS(NR), .NUM_COLUMNS(NC), .FRAMES_PER_COL(FPC), .SYNC_WORD(SYNC)
  ) dut (
    .CLK(clk), .reset(reset), .s(sif.slave),
    .FrameData(frame_data), .FrameStrobe(frame_strobe),
    .busy(busy), .done(done), .err(err)
  );

  int checks = 0;
  int errors = 0;

  // Observations, written only by the monitor.
  logic [SW-1:0]  obs_strb[$];
  logic [FDW-1:0] obs_fd[$];
  int             ready_runs[$];
  int             done_cnt = 0;
  int             low_run = 0;

  // Model expectations: every in-range WRITE yields one strobe at col*FPC+frame with its 8 words.
  int             exp_idx[$];
  logic [FDW-1:0] exp_fd[$];
  logic [31:0]    fd[NR];

  always @(negedge clk) begin
    if (frame_strobe != '0) begin
      obs_strb.push_back(frame_strobe);
      obs_fd.push_back(frame_data);
    end
    if (done === 1'b1) done_cnt++;
    if (sif.s_ready !== 1'b1) low_run++;
    else if (low_run != 0) begin
      ready_runs.push_back(low_run);
      low_run = 0;
    end
  end

  task automatic idle(input int n);
    sif.s_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push(input logic [31:0] w, input int gmax);
    int   n;
    logic rdy;
    if (gmax > 0) idle(int'($urandom_range(gmax, 0)));
    sif.s_data  = w;
    sif.s_valid = 1'b1;
    n = 0;
    rdy = 1'b0;
    while (!rdy && n < 40) begin
      @(negedge clk);
      rdy = sif.s_ready;
      @(posedge clk); #1;
      n++;
    end
    sif.s_valid = 1'b0;
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL push_timeout word=%h s_ready stayed low for %0d cycles", w, n);
    end
  endtask

  task automatic write_frame(input int col, input int fr, input int gmax);
    logic [FDW-1:0] p;
    push({8'h01, 8'(col), 16'(fr)}, gmax);
    for (int k = 0; k < NR; k++) push(fd[k], gmax);
    if (col < NC && fr < FPC) begin
      for (int k = 0; k < NR; k++) p[32*k +: 32] = fd[k];
      exp_idx.push_back(col * FPC + fr);
      exp_fd.push_back(p);
    end
  endtask

  task automatic rand_fd();
    for (int k = 0; k < NR; k++) fd[k] = $urandom;
  endtask

  task automatic test_reset();
    sif.s_valid = 1'b0;
    sif.s_data  = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (frame_data !== '0) begin errors++; $display("FAIL reset_framedata got=%h exp=0", frame_data); end
    checks++; if (frame_strobe !== '0) begin errors++; $display("FAIL reset_strobe got=%h exp=0", frame_strobe); end
    checks++; if ({sif.s_ready, busy, done, err} !== 4'b1000) begin
      errors++; $display("FAIL reset_ctrl got ready/busy/done/err=%b exp=1000", {sif.s_ready, busy, done, err});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    idle(1);
  endtask

  task automatic test_basic();
    int sb = obs_strb.size();
    int db = done_cnt;
    logic [SW-1:0]  es;
    logic [FDW-1:0] ef;
    push(SYNC, 0);
    for (int k = 0; k < NR; k++) fd[k] = 32'h1111_1111 * (k + 1);
    write_frame(2, 5, 0);
    push(END_CMD, 0);
    idle(6);
    checks++;
    if (obs_strb.size() - sb != 1) begin
      errors++; $display("FAIL basic_strobe_count got=%0d exp=1", obs_strb.size() - sb);
    end else begin
      es = '0; es[45] = 1'b1;
      ef = {32'h8888_8888, 32'h7777_7777, 32'h6666_6666, 32'h5555_5555,
            32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
      checks++; if (obs_strb[sb] !== es) begin errors++; $display("FAIL basic_strobe got=%h exp=%h", obs_strb[sb], es); end
      checks++; if (obs_fd[sb] !== ef) begin errors++; $display("FAIL basic_framedata got=%h exp=%h", obs_fd[sb], ef); end
    end
    checks++; if (done_cnt - db != 1) begin errors++; $display("FAIL basic_done got=%0d exp=1", done_cnt - db); end
    checks++; if (busy !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL basic_idle got busy=%b err=%b exp 0 0", busy, err); end
  endtask

  task automatic test_back_to_back();
    int sb = obs_strb.size();
    int eb = exp_idx.size();
    int rb = ready_runs.size();
    logic [SW-1:0] es;
    push(SYNC, 0);
    rand_fd(); write_frame(0, 0, 0);
    rand_fd(); write_frame(7, 19, 0);
    push(END_CMD, 0);
    idle(6);
    checks++;
    if (obs_strb.size() - sb != 2) begin
      errors++; $display("FAIL b2b_strobe_count got=%0d exp=2", obs_strb.size() - sb);
    end else begin
      for (int i = 0; i < 2; i++) begin
        es = '0; es[(i == 0) ? 0 : 159] = 1'b1;
        checks++; if (obs_strb[sb+i] !== es) begin errors++; $display("FAIL b2b_strobe%0d got=%h exp=%h", i, obs_strb[sb+i], es); end
        checks++; if (obs_fd[sb+i] !== exp_fd[eb+i]) begin errors++; $display("FAIL b2b_data%0d got=%h exp=%h", i, obs_fd[sb+i], exp_fd[eb+i]); end
      end
    end
    checks++;
    if (ready_runs.size() - rb != 2) begin
      errors++; $display("FAIL b2b_ready_runs got=%0d exp=2", ready_runs.size() - rb);
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++; if (ready_runs[rb+i] != 2) begin errors++; $display("FAIL b2b_ready_low%0d got=%0d exp=2", i, ready_runs[rb+i]); end
      end
    end
  endtask

  task automatic test_bad_col();
    int sb = obs_strb.size();
    int eb = exp_idx.size();
    logic [SW-1:0] es;
    push(SYNC, 0);
    rand_fd(); write_frame(8, 0, 0);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL badcol_err_set got=%b exp=1", err); end
    rand_fd(); write_frame(1, 1, 0);
    push(END_CMD, 0);
    idle(6);
    checks++;
    if (obs_strb.size() - sb != 1) begin
      errors++; $display("FAIL badcol_strobe_count got=%0d exp=1", obs_strb.size() - sb);
    end else begin
      es = '0; es[21] = 1'b1;
      checks++; if (obs_strb[sb] !== es) begin errors++; $display("FAIL badcol_strobe got=%h exp=%h", obs_strb[sb], es); end
      checks++; if (obs_fd[sb] !== exp_fd[eb]) begin errors++; $display("FAIL badcol_data got=%h exp=%h", obs_fd[sb], exp_fd[eb]); end
    end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL badcol_err_sticky got=%b exp=1", err); end
  endtask

  task automatic test_garbage_gaps();
    int sb, eb, c, f;
    reset = 1'b1; idle(2); reset = 1'b0; idle(1);
    sb = obs_strb.size();
    eb = exp_idx.size();
    for (int i = 0; i < 3; i++) push(32'hDEAD_BEEF, 2);
    checks++; if (busy !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL garbage_idle got busy=%b err=%b exp 0 0", busy, err); end
    c = int'($urandom_range(NC - 1, 0));
    f = int'($urandom_range(FPC - 1, 0));
    rand_fd();
    push(SYNC, 2);
    write_frame(c, f, 0);
    write_frame(c, f, 3);
    push(END_CMD, 2);
    idle(6);
    checks++;
    if (obs_strb.size() - sb != 2) begin
      errors++; $display("FAIL gaps_strobe_count got=%0d exp=2", obs_strb.size() - sb);
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++; if (obs_strb[sb+i] !== (SW'(1) << exp_idx[eb+i])) begin
          errors++; $display("FAIL gaps_strobe%0d got=%h exp bit %0d", i, obs_strb[sb+i], exp_idx[eb+i]);
        end
        checks++; if (obs_fd[sb+i] !== exp_fd[eb+i]) begin errors++; $display("FAIL gaps_data%0d got=%h exp=%h", i, obs_fd[sb+i], exp_fd[eb+i]); end
      end
    end
  endtask

  task automatic test_random();
    int   sb = obs_strb.size();
    int   eb = exp_idx.size();
    int   db = done_cnt;
    int   n_exp;
    logic exp_err = 1'b0;
    int   c, f;
    push(SYNC, 1);
    for (int i = 0; i < 6; i++) begin
      c = int'($urandom_range(NC + 1, 0));
      f = int'($urandom_range(FPC + 1, 0));
      if (c >= NC || f >= FPC) exp_err = 1'b1;
      rand_fd();
      if (i == 2) fd[3] = SYNC;
      write_frame(c, f, 2);
    end
    push(END_CMD, 1);
    idle(6);
    n_exp = exp_idx.size() - eb;
    checks++;
    if (obs_strb.size() - sb != n_exp) begin
      errors++; $display("FAIL rand_strobe_count got=%0d exp=%0d", obs_strb.size() - sb, n_exp);
    end else begin
      for (int i = 0; i < n_exp; i++) begin
        checks++; if (obs_strb[sb+i] !== (SW'(1) << exp_idx[eb+i])) begin
          errors++; $display("FAIL rand_strobe%0d got=%h exp bit %0d", i, obs_strb[sb+i], exp_idx[eb+i]);
        end
        checks++; if (obs_fd[sb+i] !== exp_fd[eb+i]) begin errors++; $display("FAIL rand_data%0d got=%h exp=%h", i, obs_fd[sb+i], exp_fd[eb+i]); end
      end
    end
    checks++; if (err !== exp_err) begin errors++; $display("FAIL rand_err got=%b exp=%b", err, exp_err); end
    checks++; if (done_cnt - db != 1) begin errors++; $display("FAIL rand_done got=%0d exp=1", done_cnt - db); end
  endtask

  task automatic test_reset_midframe();
    int sb = obs_strb.size();
    rand_fd();
    push(SYNC, 0);
    push({8'h01, 8'd3, 16'd3}, 0);
    for (int k = 0; k < 4; k++) push(fd[k], 0);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (frame_data !== '0) begin errors++; $display("FAIL midrst_framedata got=%h exp=0", frame_data); end
    checks++; if ({sif.s_ready, busy, frame_strobe != '0} !== 3'b100) begin
      errors++; $display("FAIL midrst_ctrl got ready/busy/strobe=%b exp=100", {sif.s_ready, busy, frame_strobe != '0});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 4; k < NR; k++) push(fd[k], 0);
    idle(6);
    checks++; if (obs_strb.size() != sb) begin errors++; $display("FAIL midrst_no_strobe got=%0d exp=0", obs_strb.size() - sb); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_idle got busy=%b exp=0", busy); end
  endtask

  task automatic test_bad_opcode();
    push(SYNC, 0);
    push(32'h7F00_0000, 0);
    idle(2);
    checks++; if (err !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL badop got err=%b busy=%b exp 1 0", err, busy); end
    push(SYNC, 0);
    checks++; if (err !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL badop_resync got err=%b busy=%b exp 0 1", err, busy); end
    push(END_CMD, 0);
    idle(3);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL badop_end got busy=%b exp=0", busy); end
  endtask

  initial begin
    sif.s_valid = 1'b0;
    sif.s_data  = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_bad_col();
    test_garbage_gaps();
    test_random();
    test_reset_midframe();
    test_bad_opcode();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
